// File: rtl/pc_sequencer.sv
// pc_sequencer
//   Registered program counter for the single-cycle MIPS datapath. Each
//   unstalled cycle it picks the next fetch address from the j/jal target,
//   the jr register target, a taken branch, or pc+4, in that priority order.
//   A circular return-address stack (RAS) records jal link values and checks
//   hinted jr returns against them. The RAS never changes the PC.
//
//   Flow control: there is no valid/ready handshake. Every rising edge with
//   stall=0 is one accepted operation (next-PC update plus at most one RAS
//   push or pop). With stall=1 nothing is accepted and all state holds.
//
// Ports
//   clk, reset      rising-edge clock, synchronous active-high reset
//   stall           hold all state for this cycle
//   jump            0 seq/branch, 1 j, 2 jr, 3 jal
//   branch_taken    conditional branch taken (ignored when jump != 0)
//   branch_offset   signed word offset of the branch
//   jindex          26-bit j/jal instruction index
//   jreg_value      rs value for jr
//   ret_hint        jr is a return through $31 (pops the RAS)
//   pc              current fetch address (registered)
//   pc_plus4        pc + 4, also the jal link value
//   ras_count       number of valid RAS entries
//   ras_overflow    sticky: push while full
//   ras_underflow   sticky: pop while empty
//   ras_mismatch    one-cycle pulse after a pop whose entry differed from jr target
//   jr_misaligned   combinational: jr with nonzero low address bits
module pc_sequencer #(
  parameter int WIDTH = 32,
  parameter int RAS_DEPTH = 8,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         stall,
  input  logic [1:0]                   jump,
  input  logic                         branch_taken,
  input  logic [15:0]                  branch_offset,
  input  logic [25:0]                  jindex,
  input  logic [WIDTH-1:0]             jreg_value,
  input  logic                         ret_hint,
  output logic [WIDTH-1:0]             pc,
  output logic [WIDTH-1:0]             pc_plus4,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ras_overflow,
  output logic                         ras_underflow,
  output logic                         ras_mismatch,
  output logic                         jr_misaligned
);

  localparam int AW = $clog2(RAS_DEPTH);
  localparam logic [AW:0] RAS_FULL = (AW+1)'(RAS_DEPTH);

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] next_pc;
  logic [WIDTH-1:0] jump_target;
  logic [WIDTH-1:0] jr_target;
  logic [WIDTH-1:0] branch_disp;

  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [AW-1:0]    top_q;     // next slot to write; top entry is top_q-1
  logic [AW-1:0]    top_dec;
  logic [AW:0]      count_q;
  logic             overflow_q;
  logic             underflow_q;
  logic             mismatch_q;
  logic             do_push;
  logic             do_pop;
  logic             ras_empty;
  logic             ras_full;
  logic [WIDTH-1:0] pop_entry;

  assign pc        = pc_q;
  assign pc_plus4  = pc_q + WIDTH'(4);

  assign jump_target = {pc_plus4[WIDTH-1:28], jindex, 2'b00};
  assign jr_target   = {jreg_value[WIDTH-1:2], 2'b00};
  // Word offset sign-extended and scaled to bytes in one concatenation.
  assign branch_disp = {{(WIDTH-18){branch_offset[15]}}, branch_offset, 2'b00};

  assign jr_misaligned = (jump == 2'd2) && (jreg_value[1:0] != 2'b00);

  always_comb begin
    next_pc = pc_plus4;
    if (jump == 2'd1 || jump == 2'd3) begin
      next_pc = jump_target;
    end else if (jump == 2'd2) begin
      next_pc = jr_target;
    end else if (branch_taken) begin
      next_pc = pc_plus4 + branch_disp;
    end
  end

  assign do_push   = (jump == 2'd3);
  assign do_pop    = (jump == 2'd2) && ret_hint;
  assign ras_empty = (count_q == '0);
  assign ras_full  = (count_q == RAS_FULL);
  assign top_dec   = top_q - AW'(1);
  assign pop_entry = ras_mem[top_dec];

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q        <= RESET_VECTOR;
      top_q       <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      mismatch_q  <= 1'b0;
    end else if (stall) begin
      mismatch_q <= 1'b0;
    end else begin
      pc_q       <= next_pc;
      mismatch_q <= 1'b0;
      if (do_push) begin
        // When full, the write pointer already sits on the oldest entry,
        // so advancing it overwrites that entry and the count saturates.
        top_q <= top_q + AW'(1);
        if (ras_full) begin
          overflow_q <= 1'b1;
        end else begin
          count_q <= count_q + (AW+1)'(1);
        end
      end else if (do_pop) begin
        if (ras_empty) begin
          underflow_q <= 1'b1;
        end else begin
          top_q      <= top_dec;
          count_q    <= count_q - (AW+1)'(1);
          mismatch_q <= (pop_entry != jr_target);
        end
      end
    end
  end

  // RAS storage carries no reset; only the pointer and count are cleared.
  always_ff @(posedge clk) begin
    if (!reset && !stall && do_push) begin
      ras_mem[top_q] <= pc_plus4;
    end
  end

  assign ras_count     = count_q;
  assign ras_overflow  = overflow_q;
  assign ras_underflow = underflow_q;
  assign ras_mismatch  = mismatch_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer
//   Directed bench for pc_sequencer (WIDTH=32, RAS_DEPTH=4,
//   RESET_VECTOR=0x0040_0000). The driver applies one operation per cycle
//   and queues the hand-computed state expected after the edge; a monitor
//   pops and compares after each edge. jr_misaligned is queued separately
//   and checked mid-cycle while its inputs are still applied.
module tb_pc_sequencer;

  localparam int W = 38;  // {pc[31:0], count[2:0], ovf, unf, mm}

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic [1:0]  jump = 2'd0;
  logic        branch_taken = 1'b0;
  logic [15:0] branch_offset = 16'h0;
  logic [25:0] jindex = 26'h0;
  logic [31:0] jreg_value = 32'h0;
  logic        ret_hint = 1'b0;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [2:0]  ras_count;
  logic        ras_overflow;
  logic        ras_underflow;
  logic        ras_mismatch;
  logic        jr_misaligned;

  logic [W-1:0] exp_q[$];
  logic         mis_q[$];
  int           checks = 0;
  int           errors = 0;

  pc_sequencer #(
    .WIDTH(32),
    .RAS_DEPTH(4),
    .RESET_VECTOR(32'h0040_0000)
  ) dut (
    .clk(clk),
    .reset(reset),
    .stall(stall),
    .jump(jump),
    .branch_taken(branch_taken),
    .branch_offset(branch_offset),
    .jindex(jindex),
    .jreg_value(jreg_value),
    .ret_hint(ret_hint),
    .pc(pc),
    .pc_plus4(pc_plus4),
    .ras_count(ras_count),
    .ras_overflow(ras_overflow),
    .ras_underflow(ras_underflow),
    .ras_mismatch(ras_mismatch),
    .jr_misaligned(jr_misaligned)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- compare helper ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  // Called at posedge+1: drives inputs, queues expectations, waits one edge.
  task automatic step(input logic r, input logic s, input logic [1:0] j,
                      input logic bt, input logic [15:0] off, input logic [25:0] ji,
                      input logic [31:0] jrv, input logic rh, input logic e_mis,
                      input logic [31:0] e_pc, input logic [2:0] e_cnt,
                      input logic e_ovf, input logic e_unf, input logic e_mm);
    reset = r;
    stall = s;
    jump = j;
    branch_taken = bt;
    branch_offset = off;
    jindex = ji;
    jreg_value = jrv;
    ret_hint = rh;
    mis_q.push_back(e_mis);
    @(posedge clk);
    exp_q.push_back({e_pc, e_cnt, e_ovf, e_unf, e_mm});
    #1;
  endtask

  task automatic idle(input logic [31:0] e_pc, input logic [2:0] e_cnt,
                      input logic e_ovf, input logic e_unf, input logic e_mm);
    step(0, 0, 2'd0, 0, 16'h0, 26'h0, 32'h0, 0, 0, e_pc, e_cnt, e_ovf, e_unf, e_mm);
  endtask

  task automatic jal(input logic [25:0] ji, input logic [31:0] e_pc, input logic [2:0] e_cnt,
                     input logic e_ovf, input logic e_unf);
    step(0, 0, 2'd3, 0, 16'h0, ji, 32'h0, 0, 0, e_pc, e_cnt, e_ovf, e_unf, 0);
  endtask

  task automatic ret(input logic [31:0] jrv, input logic [31:0] e_pc, input logic [2:0] e_cnt,
                     input logic e_ovf, input logic e_unf, input logic e_mm);
    step(0, 0, 2'd2, 0, 16'h0, 26'h0, jrv, 1, 0, e_pc, e_cnt, e_ovf, e_unf, e_mm);
  endtask

  // ---------------- monitors / scoreboard ----------------
  initial begin
    logic [W-1:0] e;
    forever begin
      @(posedge clk);
      #3;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pc",            pc,                    e[37:6]);
        chk("pc_plus4",      pc_plus4,              e[37:6] + 32'd4);
        chk("ras_count",     {29'd0, ras_count},    {29'd0, e[5:3]});
        chk("ras_overflow",  {31'd0, ras_overflow}, {31'd0, e[2]});
        chk("ras_underflow", {31'd0, ras_underflow},{31'd0, e[1]});
        chk("ras_mismatch",  {31'd0, ras_mismatch}, {31'd0, e[0]});
      end
    end
  end

  initial begin
    logic m;
    forever begin
      @(negedge clk);
      if (mis_q.size() > 0) begin
        m = mis_q.pop_front();
        chk("jr_misaligned", {31'd0, jr_misaligned}, {31'd0, m});
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    @(posedge clk);
    #1;
    // reset for two cycles, then sequential fetch
    step(1, 0, 2'd0, 0, 16'h0, 26'h0, 32'h0, 0, 0, 32'h0040_0000, 3'd0, 0, 0, 0);
    step(1, 0, 2'd0, 0, 16'h0, 26'h0, 32'h0, 0, 0, 32'h0040_0000, 3'd0, 0, 0, 0);
    idle(32'h0040_0004, 3'd0, 0, 0, 0);
    idle(32'h0040_0008, 3'd0, 0, 0, 0);
    idle(32'h0040_000C, 3'd0, 0, 0, 0);
    idle(32'h0040_0010, 3'd0, 0, 0, 0);
    // backward branch of -1 word lands on itself
    step(0, 0, 2'd0, 1, 16'hFFFF, 26'h0, 32'h0, 0, 0, 32'h0040_0010, 3'd0, 0, 0, 0);
    // j wins over a taken branch
    step(0, 0, 2'd1, 1, 16'h0005, 26'h010_0000, 32'h0, 0, 0, 32'h0040_0000, 3'd0, 0, 0, 0);
    // forward branch +7 words: 0x400004 + 28
    step(0, 0, 2'd0, 1, 16'd7, 26'h0, 32'h0, 0, 0, 32'h0040_0020, 3'd0, 0, 0, 0);
    // matched call/return
    jal(26'h010_0010, 32'h0040_0040, 3'd1, 0, 0);
    ret(32'h0040_0024, 32'h0040_0024, 3'd0, 0, 0, 0);
    // back to 0x400020 (branch -2 words), call again, return to wrong address
    step(0, 0, 2'd0, 1, 16'hFFFE, 26'h0, 32'h0, 0, 0, 32'h0040_0020, 3'd0, 0, 0, 0);
    jal(26'h010_0010, 32'h0040_0040, 3'd1, 0, 0);
    ret(32'h0040_0028, 32'h0040_0028, 3'd0, 0, 0, 1);
    idle(32'h0040_002C, 3'd0, 0, 0, 0);
    // five calls into a 4-deep RAS
    jal(26'h010_0100, 32'h0040_0400, 3'd1, 0, 0);
    jal(26'h010_0200, 32'h0040_0800, 3'd2, 0, 0);
    jal(26'h010_0300, 32'h0040_0C00, 3'd3, 0, 0);
    jal(26'h010_0400, 32'h0040_1000, 3'd4, 0, 0);
    jal(26'h010_0500, 32'h0040_1400, 3'd4, 1, 0);
    // LIFO returns through the last four link values
    ret(32'h0040_1004, 32'h0040_1004, 3'd3, 1, 0, 0);
    ret(32'h0040_0C04, 32'h0040_0C04, 3'd2, 1, 0, 0);
    ret(32'h0040_0804, 32'h0040_0804, 3'd1, 1, 0, 0);
    ret(32'h0040_0404, 32'h0040_0404, 3'd0, 1, 0, 0);
    // underflow: pc still follows jreg_value, flag sticks
    ret(32'h0040_0100, 32'h0040_0100, 3'd0, 1, 1, 0);
    idle(32'h0040_0104, 3'd0, 1, 1, 0);
    // call, then stalled jal/jr must not touch pc or the RAS
    jal(26'h010_0080, 32'h0040_0200, 3'd1, 1, 1);
    step(0, 1, 2'd3, 0, 16'h0, 26'h010_0500, 32'h0, 0, 0, 32'h0040_0200, 3'd1, 1, 1, 0);
    step(0, 1, 2'd3, 0, 16'h0, 26'h010_0500, 32'h0, 0, 0, 32'h0040_0200, 3'd1, 1, 1, 0);
    step(0, 1, 2'd3, 0, 16'h0, 26'h010_0500, 32'h0, 0, 0, 32'h0040_0200, 3'd1, 1, 1, 0);
    step(0, 1, 2'd2, 0, 16'h0, 26'h0, 32'h0000_0123, 1, 1, 32'h0040_0200, 3'd1, 1, 1, 0);
    // the pre-stall link value is still on top
    ret(32'h0040_0108, 32'h0040_0108, 3'd0, 1, 1, 0);
    // unhinted misaligned jr: low bits dropped, RAS untouched
    step(0, 0, 2'd2, 0, 16'h0, 26'h0, 32'h0040_0033, 0, 1, 32'h0040_0030, 3'd0, 1, 1, 0);
    // reset mid call chain, overriding stall and jal
    jal(26'h010_0010, 32'h0040_0040, 3'd1, 1, 1);
    step(1, 1, 2'd3, 0, 16'h0, 26'h010_0100, 32'h0, 0, 0, 32'h0040_0000, 3'd0, 0, 0, 0);
    ret(32'h0040_0024, 32'h0040_0024, 3'd0, 0, 1, 0);
    idle(32'h0040_0028, 3'd0, 0, 1, 0);

    repeat (3) @(posedge clk);
    #4;
    chk("queues_drained", exp_q.size() + mis_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
